// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline segment register.
//   seg_state_e : segment occupancy state; the encoding doubles as the occ output.
//   SEG_OCC_W   : width of the occupancy count.
package pipe_pkg;
   localparam int SEG_OCC_W = 2;

   typedef enum logic [SEG_OCC_W-1:0] {
      SEG_EMPTY = 2'd0,
      SEG_ONE   = 2'd1,
      SEG_TWO   = 2'd2
   } seg_state_e;
endpackage

// File: rtl/pipe_seg_skid.sv
// pipe_seg_skid: skid data register for pipe_seg_hs.
// It catches the payload that arrives while the main register is stalled,
// and hands it back when the main register drains.
//   clk, resetn : clock, asynchronous active-low reset
//   load        : capture in_data into the skid register
//   in_data     : payload to capture
//   data        : held skid payload (RST_DATA after reset)
//   unload      : main register takes the skid payload this cycle
//   unload_data : payload for the main register, valid while unload is high
module pipe_seg_skid
   import pipe_pkg::*;
#(
   parameter int             DW       = 160,
   parameter logic [DW-1:0]  RST_DATA = '0
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          load,
   input  logic [DW-1:0] in_data,
   input  logic          unload,
   output logic [DW-1:0] data,
   output logic [DW-1:0] unload_data
);
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)   data <= RST_DATA;
      else if (load) data <= in_data;
   end

   // The skid register keeps its contents after unloading; the state machine
   // treats it as empty, so the stale value is never presented.
   assign unload_data = unload ? data : RST_DATA;
endmodule

// File: rtl/pipe_seg_hs.sv
// pipe_seg_hs: parametrised pipeline segment register with valid/ready
// handshake, flush, and an optional 2-entry skid buffer.
// Build option: define PIPE_SEG_SKID_EN to add the skid register and state TWO,
// which makes in_ready a registered output. Without it, in_ready is
// !out_valid | out_ready (combinational from out_ready).
//   clk, resetn          : clock, asynchronous active-low reset
//   flush                : kill held and incoming entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload
//   occ                  : number of held entries
module pipe_seg_hs
   import pipe_pkg::*;
#(
   parameter int             DW       = 160,
   parameter logic [DW-1:0]  RST_DATA = '0
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DW-1:0]        in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DW-1:0]        out_data,
   output logic [SEG_OCC_W-1:0] occ
);
   seg_state_e    state, state_n;
   logic [DW-1:0] main_q;
   logic          in_fire, out_fire;
   logic          main_ld_in;   // main <- in_data
   logic          main_ld_skid; // main <- skid
   logic          skid_ld;      // skid <- in_data

   assign in_fire  = in_valid & in_ready;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_n      = state;
      main_ld_in   = 1'b0;
      main_ld_skid = 1'b0;
      skid_ld      = 1'b0;
      case (state)
         SEG_EMPTY: if (in_fire) begin
            state_n    = SEG_ONE;
            main_ld_in = 1'b1;
         end
         SEG_ONE: begin
            if (in_fire && out_fire) begin
               main_ld_in = 1'b1;
            end else if (out_fire) begin
               state_n = SEG_EMPTY;
`ifdef PIPE_SEG_SKID_EN
            end else if (in_fire) begin
               state_n = SEG_TWO;
               skid_ld = 1'b1;
`endif
            end
         end
`ifdef PIPE_SEG_SKID_EN
         SEG_TWO: if (out_fire) begin
            state_n      = SEG_ONE;
            main_ld_skid = 1'b1;
         end
`endif
         default: state_n = SEG_EMPTY;
      endcase
      // Flush wins over every transition; register contents may stay stale.
      if (flush) begin
         state_n      = SEG_EMPTY;
         main_ld_in   = 1'b0;
         main_ld_skid = 1'b0;
         skid_ld      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= SEG_EMPTY;
      else         state <= state_n;
   end

`ifdef PIPE_SEG_SKID_EN
   logic [DW-1:0] skid_data, skid_unload_data;
   logic          in_ready_q;

   pipe_seg_skid #(.DW(DW), .RST_DATA(RST_DATA)) u_skid (
      .clk         (clk),
      .resetn      (resetn),
      .load        (skid_ld),
      .in_data     (in_data),
      .unload      (main_ld_skid),
      .data        (skid_data),
      .unload_data (skid_unload_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)           main_q <= RST_DATA;
      else if (main_ld_in)   main_q <= in_data;
      else if (main_ld_skid) main_q <= skid_unload_data;
   end

   // Registered copy of (state != TWO), computed from the next state so it
   // lines up with the state register without any input-to-output path.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) in_ready_q <= 1'b1;
      else         in_ready_q <= (state_n != SEG_TWO);
   end
   assign in_ready = in_ready_q;
`else
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)         main_q <= RST_DATA;
      else if (main_ld_in) main_q <= in_data;
   end

   assign in_ready = !out_valid | out_ready;
`endif

   assign out_valid = (state != SEG_EMPTY);
   assign out_data  = main_q;
   assign occ       = state;
endmodule

// File: tb/tb_pipe_seg_hs.sv
// tb_pipe_seg_hs: self-checking bench for pipe_seg_hs (DW=32).
// A negedge monitor keeps a scoreboard of accepted payloads and checks every
// delivered payload against it in order; scenario tasks add direct checks.
module tb_pipe_seg_hs;
   import pipe_pkg::*;
   localparam int DW = 32;

   logic                 clk = 1'b0;
   logic                 resetn = 1'b0;
   logic                 flush = 1'b0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DW-1:0]        in_data = '0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [DW-1:0]        out_data;
   logic [SEG_OCC_W-1:0] occ;

   int checks = 0;
   int errors = 0;
   int delivered = 0;
   logic [DW-1:0] sb[$];

   pipe_seg_hs #(.DW(DW), .RST_DATA('0)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occ       (occ)
   );

   always #5 clk = ~clk;

   // Inputs change 1 time unit after posedge, so at negedge the handshakes
   // that the next posedge will see are stable.
   always @(negedge clk) begin
      if (!resetn) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            checks++;
            delivered++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL deliver_unexpected got %h expected none", out_data);
            end else begin
               logic [DW-1:0] exp;
               exp = sb.pop_front();
               if (out_data !== exp) begin
                  errors++;
                  $display("FAIL deliver_order got %h expected %h", out_data, exp);
               end
            end
         end
         if (flush) sb.delete();
         else if (in_valid && in_ready) sb.push_back(in_data);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, got, exp);
      end
   endtask

   task automatic drain();
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      chk("drain_occ", DW'(occ), 0);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) step();
      resetn = 1'b1;
      step();
      in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
      #1 resetn = 1'b0;
      #1;
      chk("rst_out_valid", DW'(out_valid), 0);
      chk("rst_occ", DW'(occ), 0);
      chk("rst_in_ready", DW'(in_ready), 1);
      chk("rst_out_data", out_data, 0);
      step();
      in_valid = 1'b0;
      step();
      resetn = 1'b1;
      step();
      chk("rst_no_transfer_valid", DW'(out_valid), 0);
      chk("rst_no_transfer_occ", DW'(occ), 0);
   endtask

   task automatic test_stream();
      int d0;
      d0 = delivered;
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i > 0) begin
            chk("stream_valid", DW'(out_valid), 1);
            chk("stream_data", out_data, DW'(32'h10 + i - 1));
         end
         if (i < 8) begin
            in_valid = 1'b1; in_data = DW'(32'h10 + i);
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      drain();
      chk("stream_count", DW'(delivered - d0), 8);
   endtask

   task automatic test_backpressure();
      int d0;
      d0 = delivered;
      out_ready = 1'b0;
`ifdef PIPE_SEG_SKID_EN
      in_valid = 1'b1; in_data = 32'hA0;
      step();
      in_data = 32'hA1;
      step();
      in_valid = 1'b0;
      chk("bp_occ2", DW'(occ), 2);
      chk("bp_in_ready0", DW'(in_ready), 0);
      chk("bp_hold", out_data, 32'hA0);
      step();
      chk("bp_hold_again", out_data, 32'hA0);
      out_ready = 1'b1;
      step();
      chk("bp_second", out_data, 32'hA1);
      chk("bp_occ1", DW'(occ), 1);
      drain();
      chk("bp_count", DW'(delivered - d0), 2);
`else
      in_valid = 1'b1; in_data = 32'hB0;
      step();
      in_valid = 1'b0;
      chk("bp_hold", out_data, 32'hB0);
      chk("bp_in_ready0", DW'(in_ready), 0);
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_comb", DW'(in_ready), 1);
      drain();
      chk("bp_count", DW'(delivered - d0), 1);
`endif
   endtask

   task automatic test_flush();
      int d0;
      d0 = delivered;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hC0;
      step();
`ifdef PIPE_SEG_SKID_EN
      in_data = 32'hC1;
      step();
      chk("flush_pre_occ", DW'(occ), 2);
`endif
      in_data = 32'hC2; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_valid", DW'(out_valid), 0);
      chk("flush_occ", DW'(occ), 0);
      chk("flush_in_ready", DW'(in_ready), 1);
      // Flush together with an accepted handshake from EMPTY.
      in_valid = 1'b1; in_data = 32'hC3; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_drop_valid", DW'(out_valid), 0);
      out_ready = 1'b1;
      repeat (3) step();
      chk("flush_none_delivered", DW'(delivered - d0), 0);
   endtask

   task automatic test_simul();
      int d0;
      d0 = delivered;
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 32'hD0;
      step();
      in_data = 32'hD1; out_ready = 1'b1;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      chk("simul_data", out_data, 32'hD1);
      chk("simul_occ", DW'(occ), 1);
      chk("simul_delivered", DW'(delivered - d0), 1);
      drain();
      chk("simul_count", DW'(delivered - d0), 2);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_simul();
      chk("sb_empty", DW'(sb.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
